// File: rtl/pipeline_control_unit_if.sv
// Pipeline control bundle: ID/EX/WB hazard inputs toward the control unit,
// and stall/flush controls plus performance counters back to the datapath.
//   master : datapath side (drives ID/EX/WB status, receives controls)
//   slave  : pipeline_control_unit side
// Optional PIPELINE_STALL_STATS_EN adds stall_count / flush_count.
interface pipeline_control_unit_if #(
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic [31:0]      id_instr;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             ex_branch_taken;
  logic             wb_valid;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             stall_active;
  logic             end_program;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] retire_count;
`ifdef PIPELINE_STALL_STATS_EN
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_valid, id_instr, id_rs1, id_rs2, ex_mem_read, ex_rd,
           ex_branch_taken, wb_valid,
    input  pc_write, ifid_write, ifid_flush, idex_flush, stall_active,
           end_program, cycle_count, retire_count, stall_count, flush_count
  );
  modport slave (
    input  id_valid, id_instr, id_rs1, id_rs2, ex_mem_read, ex_rd,
           ex_branch_taken, wb_valid,
    output pc_write, ifid_write, ifid_flush, idex_flush, stall_active,
           end_program, cycle_count, retire_count, stall_count, flush_count
  );
`else
  modport master (
    output id_valid, id_instr, id_rs1, id_rs2, ex_mem_read, ex_rd,
           ex_branch_taken, wb_valid,
    input  pc_write, ifid_write, ifid_flush, idex_flush, stall_active,
           end_program, cycle_count, retire_count
  );
  modport slave (
    input  id_valid, id_instr, id_rs1, id_rs2, ex_mem_read, ex_rd,
           ex_branch_taken, wb_valid,
    output pc_write, ifid_write, ifid_flush, idex_flush, stall_active,
           end_program, cycle_count, retire_count
  );
`endif
endinterface

// File: rtl/pipeline_control_unit.sv
// Central sequencer for the 5-stage core: load-use stall, taken-branch flush,
// halt detection with a fixed drain period, and cycle/retire counters.
// Ports:
//   clk   : core clock, rising edge
//   reset : synchronous, active-low
//   bus   : pipeline_control_unit_if.slave (hazard inputs, controls, counters)
// Optional feature macro PIPELINE_STALL_STATS_EN: adds saturating stall_count
// (load-use stall cycles) and flush_count (branch-flush cycles).
module pipeline_control_unit #(
  parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF,
  parameter int          DRAIN_CYCLES = 4,
  parameter int          CNT_W        = 32
) (
  input logic              clk,
  input logic              reset,
  pipeline_control_unit_if.slave bus
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  state_t           state;
  logic [3:0]       drain_q;
  logic             end_q;
  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] ret_q;

  logic halt_det, load_use, branch_flush;
  logic pc_write, ifid_write, ifid_flush, idex_flush, stall_active;

  assign halt_det = bus.id_valid && (bus.id_instr == HALT_WORD);
  assign load_use = bus.id_valid && bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                    ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));

  // Branch beats halt beats load-use; a halt behind a taken branch is on the
  // wrong path and must not stop the machine.
  always_comb begin
    pc_write     = 1'b0;
    ifid_write   = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    stall_active = 1'b0;
    branch_flush = 1'b0;
    if (!reset) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      case (state)
        RUN: begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          if (bus.ex_branch_taken) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            branch_flush = 1'b1;
          end else if (halt_det) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
          end else if (load_use) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_flush   = 1'b1;
            stall_active = 1'b1;
          end
        end
        DRAIN: idex_flush = 1'b1;
        default: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end
      endcase
    end
  end

  // Drain counter is loaded with DRAIN_CYCLES-1 and HALTED is entered on the
  // edge where it reads 0, so DRAIN spans exactly DRAIN_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= RUN;
      drain_q <= '0;
      end_q   <= 1'b0;
      cyc_q   <= '0;
      ret_q   <= '0;
    end else begin
      case (state)
        RUN: if (!bus.ex_branch_taken && halt_det) begin
          state   <= DRAIN;
          drain_q <= DRAIN_INIT;
        end
        DRAIN: if (drain_q == 4'd0) begin
          state <= HALTED;
          end_q <= 1'b1;
        end else begin
          drain_q <= drain_q - 4'd1;
        end
        default: ;
      endcase
      if (state != HALTED) begin
        if (cyc_q != '1) cyc_q <= cyc_q + CNT_W'(1);
        if (bus.wb_valid && ret_q != '1) ret_q <= ret_q + CNT_W'(1);
      end
    end
  end

  assign bus.pc_write     = pc_write;
  assign bus.ifid_write   = ifid_write;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_flush   = idex_flush;
  assign bus.stall_active = stall_active;
  assign bus.end_program  = end_q;
  assign bus.cycle_count  = cyc_q;
  assign bus.retire_count = ret_q;

`ifdef PIPELINE_STALL_STATS_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  // stall_active / branch_flush are only ever high in RUN, which keeps these
  // frozen in DRAIN and HALTED without an explicit state check.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_active && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
      if (branch_flush && flush_q != '1) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign bus.stall_count = stall_q;
  assign bus.flush_count = flush_q;
`endif
endmodule
